// File: rtl/cache_pkg.sv
// Purpose: shared field widths, types and write-type encodings for the direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    // Reference geometry: 10-bit byte address, 32 lines, 4 words per line.
    localparam int ADDR_W_DEF        = 10;
    localparam int NUM_LINES_DEF     = 32;
    localparam int WORDS_PER_BLK_DEF = 4;
    localparam int CNT_W_DEF         = 16;

    localparam int WO_W  = $clog2(WORDS_PER_BLK_DEF);
    localparam int IDX_W = $clog2(NUM_LINES_DEF);
    localparam int TAG_W = ADDR_W_DEF - 2 - WO_W - IDX_W;
    localparam int BLK_W = 32 * WORDS_PER_BLK_DEF;

    typedef logic [31:0]                          word_t;
    typedef logic [TAG_W-1:0]                     tag_t;
    // Packed so that word 0 sits in bits [31:0], matching the memory block layout.
    typedef word_t [WORDS_PER_BLK_DEF-1:0]        block_t;

    // cache_w_type encodings driven by cache_ctrl.
    localparam logic CW_FILL = 1'b0;
    localparam logic CW_WORD = 1'b1;

endpackage

// File: rtl/cache_perf_cnt.sv
// Purpose: classify each core access once as hit or miss and keep saturating hit/miss counters.
// Latency: counters update on the falling edge that first sees a new access.
// Backpressure: none; purely observes the request stream.
//
// Ports: clk/rstn (falling-edge state, async active-low reset), addr/memRd/memWr (core request),
//        hit (combinational cache_status), hit_cnt/miss_cnt (counter outputs).
module cache_perf_cnt
    import cache_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] addr,
    input  logic              memRd,
    input  logic              memWr,
    input  logic              hit,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    logic              counted;
    logic [ADDR_W-1:0] last_addr;
    logic              last_op;
    logic              req;
    logic              op;

    assign req = memRd | memWr;
    // A store wins when both strobes are high.
    assign op  = memWr;

    // An access that stalls across several edges (e.g. a read miss waiting for its fill)
    // is counted only on its first edge; any change of address or op, or an idle edge,
    // re-arms classification for the next edge.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            counted   <= 1'b0;
            last_addr <= '0;
            last_op   <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else if (counted) begin
            if (!req || (addr != last_addr) || (op != last_op)) begin
                counted <= 1'b0;
            end
        end else if (req) begin
            counted   <= 1'b1;
            last_addr <= addr;
            last_op   <= op;
            if (hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_array.sv
// Purpose: direct-mapped write-through cache storage (tag/valid/data), hit detection and perf counters.
// Latency: hit/rdata combinational; array writes on the falling edge with cache_wen.
// Backpressure: none; cache_ctrl sequences fills and word writes.
//
// Ports: clk/rstn, addr/memRd/memWr/wdata (core), cache_wen/cache_w_type/mm_rdata (controller and
//        main memory), cache_status/rdata (hit and load data), hit_cnt/miss_cnt (perf counters).
module cache_array
    import cache_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int NUM_LINES     = NUM_LINES_DEF,
    parameter int WORDS_PER_BLK = WORDS_PER_BLK_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        memRd,
    input  logic                        memWr,
    input  logic [31:0]                 wdata,
    input  logic                        cache_wen,
    input  logic                        cache_w_type,
    input  logic [32*WORDS_PER_BLK-1:0] mm_rdata,
    output logic                        cache_status,
    output logic [31:0]                 rdata,
    output logic [CNT_W-1:0]            hit_cnt,
    output logic [CNT_W-1:0]            miss_cnt
);

    localparam int WO_BITS  = $clog2(WORDS_PER_BLK);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = ADDR_W - 2 - WO_BITS - IDX_BITS;

    logic [WO_BITS-1:0]  word_off;
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] addr_tag;
    logic [1:0]          unused_byte_off;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
    word_t                data_mem [NUM_LINES][WORDS_PER_BLK];

    // Accesses are word-aligned; the byte offset carries no information.
    assign unused_byte_off = addr[1:0];
    assign word_off        = addr[2 +: WO_BITS];
    assign idx             = addr[2+WO_BITS +: IDX_BITS];
    assign addr_tag        = addr[ADDR_W-1 -: TAG_BITS];

    assign cache_status = (memRd | memWr) && valid[idx] && (tag_mem[idx] == addr_tag);
    assign rdata        = cache_status ? data_mem[idx][word_off] : 32'h0;

    // Only valid bits are reset; tag/data contents are meaningless until a fill sets valid.
    always_ff @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= '0;
        end else if (cache_wen && (cache_w_type == CW_FILL)) begin
            valid[idx] <= 1'b1;
        end
    end

    // Fills overwrite the whole line unconditionally: write-through means no dirty data to
    // evict. Writes are suppressed while reset is held so a fill in flight is dropped.
    always_ff @(negedge clk) begin
        if (cache_wen && rstn) begin
            if (cache_w_type == CW_WORD) begin
                data_mem[idx][word_off] <= wdata;
            end else begin
                for (int w = 0; w < WORDS_PER_BLK; w++) begin
                    data_mem[idx][w] <= mm_rdata[32*w +: 32];
                end
                tag_mem[idx] <= addr_tag;
            end
        end
    end

    cache_perf_cnt #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_perf_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .addr     (addr),
        .memRd    (memRd),
        .memWr    (memWr),
        .hit      (cache_status),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

endmodule

// File: tb/tb_cache_array.sv
// Purpose: directed self-checking bench for cache_array (reset, fill, write hit, conflict, saturation).
// Latency: inputs driven 1 time unit after each falling edge; outputs sampled shortly after.
// Backpressure: n/a.
module tb_cache_array;

    localparam int TB_CNT_W = 8;

    logic         clk = 1'b0;
    logic         rstn;
    logic [9:0]   addr;
    logic         memRd;
    logic         memWr;
    logic [31:0]  wdata;
    logic         cache_wen;
    logic         cache_w_type;
    logic [127:0] mm_rdata;
    logic         cache_status;
    logic [31:0]  rdata;
    logic [TB_CNT_W-1:0] hit_cnt;
    logic [TB_CNT_W-1:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    cache_array #(
        .ADDR_W        (10),
        .NUM_LINES     (32),
        .WORDS_PER_BLK (4),
        .CNT_W         (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .addr         (addr),
        .memRd        (memRd),
        .memWr        (memWr),
        .wdata        (wdata),
        .cache_wen    (cache_wen),
        .cache_w_type (cache_w_type),
        .mm_rdata     (mm_rdata),
        .cache_status (cache_status),
        .rdata        (rdata),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        memRd     = 1'b0;
        memWr     = 1'b0;
        cache_wen = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; addr = 10'h0; memRd = 1'b0; memWr = 1'b0; wdata = 32'h0;
        cache_wen = 1'b0; cache_w_type = 1'b0; mm_rdata = '0;
        tick(); tick();
        checks++; if (cache_status !== 1'b0) begin errors++; $display("FAIL reset_status: got %b want 0", cache_status); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
        checks++; if (miss_cnt !== 8'd0) begin errors++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
        @(posedge clk); rstn = 1'b1;
        tick();
        memRd = 1'b1; addr = 10'h040;
        #1;
        checks++; if (cache_status !== 1'b0) begin errors++; $display("FAIL cold_rd_status: got %b want 0", cache_status); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL cold_rd_rdata: got %h want 0", rdata); end
        tick();
        checks++; if (miss_cnt !== 8'd1) begin errors++; $display("FAIL cold_rd_miss_cnt: got %0d want 1", miss_cnt); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL cold_rd_hit_cnt: got %0d want 0", hit_cnt); end
    endtask

    task automatic test_fill();
        addr = 10'h044; mm_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
        cache_wen = 1'b1; cache_w_type = 1'b0;
        #1;
        checks++; if (cache_status !== 1'b0) begin errors++; $display("FAIL fill_pre_status: got %b want 0", cache_status); end
        tick();
        checks++; if (cache_status !== 1'b1) begin errors++; $display("FAIL fill_status: got %b want 1", cache_status); end
        checks++; if (rdata !== 32'hB) begin errors++; $display("FAIL fill_rdata: got %h want b", rdata); end
        checks++; if (miss_cnt !== 8'd1) begin errors++; $display("FAIL fill_miss_cnt: got %0d want 1", miss_cnt); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL fill_hit_cnt: got %0d want 0", hit_cnt); end
        idle();
        checks++; if (cache_status !== 1'b0) begin errors++; $display("FAIL noreq_status: got %b want 0", cache_status); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL noreq_rdata: got %h want 0", rdata); end
    endtask

    task automatic test_write_hit();
        memWr = 1'b1; addr = 10'h048; wdata = 32'h1234;
        cache_wen = 1'b1; cache_w_type = 1'b1;
        #1;
        checks++; if (cache_status !== 1'b1) begin errors++; $display("FAIL wr_hit_status: got %b want 1", cache_status); end
        tick();
        checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL wr_hit_cnt: got %0d want 1", hit_cnt); end
        checks++; if (miss_cnt !== 8'd1) begin errors++; $display("FAIL wr_miss_cnt: got %0d want 1", miss_cnt); end
        idle();
        memRd = 1'b1; addr = 10'h048;
        #1;
        checks++; if (rdata !== 32'h1234) begin errors++; $display("FAIL wr_readback: got %h want 1234", rdata); end
        addr = 10'h044;
        #1;
        checks++; if (rdata !== 32'hB) begin errors++; $display("FAIL wr_neighbour: got %h want b", rdata); end
        idle();
    endtask

    task automatic test_conflict();
        memRd = 1'b1; addr = 10'h040; mm_rdata = {32'h4, 32'h3, 32'h2, 32'h1};
        cache_wen = 1'b1; cache_w_type = 1'b0;
        tick();
        addr = 10'h240; mm_rdata = {32'h8, 32'h7, 32'h6, 32'h5};
        tick();
        cache_wen = 1'b0; addr = 10'h040;
        #1;
        checks++; if (cache_status !== 1'b0) begin errors++; $display("FAIL conflict_old_status: got %b want 0", cache_status); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL conflict_old_rdata: got %h want 0", rdata); end
        addr = 10'h240;
        #1;
        checks++; if (cache_status !== 1'b1) begin errors++; $display("FAIL conflict_new_status: got %b want 1", cache_status); end
        checks++; if (rdata !== 32'h5) begin errors++; $display("FAIL conflict_new_rdata: got %h want 5", rdata); end
        addr = 10'h24C;
        #1;
        checks++; if (rdata !== 32'h8) begin errors++; $display("FAIL conflict_word3: got %h want 8", rdata); end
        idle();
    endtask

    task automatic test_saturation();
        rstn = 1'b0;
        tick();
        @(posedge clk); rstn = 1'b1;
        tick();
        memRd = 1'b1; addr = 10'h240; mm_rdata = {32'h8, 32'h7, 32'h6, 32'h5};
        cache_wen = 1'b1; cache_w_type = 1'b0;
        tick();
        checks++; if (miss_cnt !== 8'd1) begin errors++; $display("FAIL sat_fill_miss: got %0d want 1", miss_cnt); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL sat_fill_hit: got %0d want 0", hit_cnt); end
        idle();
        // Alternate between two words of the resident line: each address change is a new access.
        for (int i = 0; i < (1 << TB_CNT_W) + 3; i++) begin
            memRd = 1'b1;
            addr  = i[0] ? 10'h244 : 10'h240;
            tick(); tick();
            if (i == 253) begin
                checks++; if (hit_cnt !== 8'd254) begin errors++; $display("FAIL sat_pre: got %0d want 254", hit_cnt); end
            end
        end
        checks++; if (hit_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hit_cnt: got %h want ff", hit_cnt); end
        checks++; if (miss_cnt !== 8'd1) begin errors++; $display("FAIL sat_miss_cnt: got %0d want 1", miss_cnt); end
        idle();
    endtask

    task automatic test_reset_mid_fill();
        memRd = 1'b1; addr = 10'h044; mm_rdata = {32'hD, 32'hC, 32'hB, 32'hA};
        cache_wen = 1'b1; cache_w_type = 1'b0;
        @(posedge clk); rstn = 1'b0;
        tick();
        checks++; if (cache_status !== 1'b0) begin errors++; $display("FAIL rstfill_in_rst_status: got %b want 0", cache_status); end
        @(posedge clk); cache_wen = 1'b0; rstn = 1'b1;
        #1;
        checks++; if (cache_status !== 1'b0) begin errors++; $display("FAIL rstfill_status: got %b want 0", cache_status); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstfill_rdata: got %h want 0", rdata); end
        checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL rstfill_hit_cnt: got %0d want 0", hit_cnt); end
        checks++; if (miss_cnt !== 8'd0) begin errors++; $display("FAIL rstfill_miss_cnt: got %0d want 0", miss_cnt); end
        tick();
        checks++; if (miss_cnt !== 8'd1) begin errors++; $display("FAIL rstfill_post_miss: got %0d want 1", miss_cnt); end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_hit();
        test_conflict();
        test_saturation();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
